// File: rtl/joy2quad_pkg.sv
// Shared definitions for the joystick-to-quadrature encoder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: the four Gray states, the direction encoding and quad_next().
package joy2quad_pkg;

  // The +1 direction walks the Gray cycle 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] QUAD_00 = 2'b00;
  localparam logic [1:0] QUAD_01 = 2'b01;
  localparam logic [1:0] QUAD_11 = 2'b11;
  localparam logic [1:0] QUAD_10 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } dir_e;

  // Both buttons pressed cancel each other out.
  function automatic dir_e decode_dir(input logic right, input logic left);
    dir_e d;
    d = IDLE;
    if (right && !left) d = POS;
    else if (left && !right) d = NEG;
    return d;
  endfunction

  // Next Gray state for one step; IDLE leaves the state alone.
  function automatic logic [1:0] quad_next(input logic [1:0] state, input dir_e dir);
    logic [1:0] nxt;
    nxt = state;
    case (dir)
      POS: begin
        case (state)
          QUAD_00: nxt = QUAD_01;
          QUAD_01: nxt = QUAD_11;
          QUAD_11: nxt = QUAD_10;
          default: nxt = QUAD_00;
        endcase
      end
      NEG: begin
        case (state)
          QUAD_00: nxt = QUAD_10;
          QUAD_10: nxt = QUAD_11;
          QUAD_11: nxt = QUAD_01;
          default: nxt = QUAD_00;
        endcase
      end
      default: nxt = state;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/joy2quad_chan.sv
// One encoder channel: prescaler, acceleration level, step counter, Gray register.
// Latency: direction first sampled at edge t -> first steer change after edge t+P.
// Backpressure: none; the channel free-runs while its direction is held.
// Ports: clk_sys/rst_n clock and async active-low reset; clkdiv base period;
//        right/left requests; steer {A,B}; moving; level (0 = slowest).
module joy2quad_chan
  import joy2quad_pkg::*;
#(
  parameter int DIV_W           = 16,
  parameter int ACCEL_LEVELS    = 3,
  parameter int STEPS_PER_LEVEL = 4
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic             right,
  input  logic             left,
  output logic [1:0]       steer,
  output logic             moving,
  output logic [1:0]       level
);

  localparam int              SC_W    = (STEPS_PER_LEVEL < 2) ? 1 : $clog2(STEPS_PER_LEVEL + 1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STEPS_PER_LEVEL);
  localparam logic [1:0]      LVL_TOP = 2'(ACCEL_LEVELS - 1);

  dir_e             dir;
  dir_e             prev_dir;
  logic             reversal;
  logic             active;
  logic [DIV_W-1:0] base_period;
  logic [DIV_W-1:0] shifted;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] cnt;
  logic             fire;
  logic             fire_q;
  logic [SC_W-1:0]  step_cnt;
  logic [SC_W-1:0]  step_cnt_inc;
  logic             level_up;

  always_comb begin
    dir          = decode_dir(right, left);
    // A direct POS<->NEG flip costs one dead cycle so the new direction
    // restarts from level 0 with a full period.
    reversal     = ((dir == POS) && (prev_dir == NEG)) ||
                   ((dir == NEG) && (prev_dir == POS));
    active       = (dir != IDLE) && !reversal;
    base_period  = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
    shifted      = base_period >> level;
    period       = (shifted == '0) ? DIV_W'(1) : shifted;
    // >= rather than == so a period that shrinks mid-count fires at once.
    fire         = active && (cnt >= (period - DIV_W'(1)));
    step_cnt_inc = step_cnt + SC_W'(1);
    level_up     = (level < LVL_TOP) && (step_cnt_inc >= SC_MAX);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      prev_dir <= IDLE;
      moving   <= 1'b0;
      steer    <= QUAD_00;
      level    <= 2'd0;
      cnt      <= '0;
      step_cnt <= '0;
      fire_q   <= 1'b0;
    end else begin
      prev_dir <= dir;
      moving   <= active;
      if (!active) begin
        // Idle (or reversal): steer holds, everything else restarts.
        cnt      <= '0;
        level    <= 2'd0;
        step_cnt <= '0;
        fire_q   <= 1'b0;
      end else begin
        // The step decided last edge lands on steer now.
        if (fire_q) steer <= quad_next(steer, dir);
        fire_q <= fire;
        if (fire) begin
          cnt <= '0;
          if (level_up) begin
            level    <= level + 2'd1;
            step_cnt <= '0;
          end else if (step_cnt != SC_MAX) begin
            step_cnt <= step_cnt_inc;
          end
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/joy2quad_mc.sv
// Multi-channel joystick-to-quadrature encoder for spinner/paddle inputs.
// Latency: per channel, direction sampled at edge t -> steer change after edge t+P.
// Backpressure: none; channels are independent and never stall.
// Ports: CLK, Reset_n (async active-low); clkdiv shared base period;
//        right/left per channel; steer[2c+1]=A, steer[2c]=B; moving; level[2c+1:2c].
module joy2quad_mc
  import joy2quad_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int DIV_W           = 16,
  parameter int ACCEL_LEVELS    = 3,
  parameter int STEPS_PER_LEVEL = 4
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic [CHANNELS-1:0]   right,
  input  logic [CHANNELS-1:0]   left,
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   moving,
  output logic [2*CHANNELS-1:0] level
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    joy2quad_chan #(
      .DIV_W          (DIV_W),
      .ACCEL_LEVELS   (ACCEL_LEVELS),
      .STEPS_PER_LEVEL(STEPS_PER_LEVEL)
    ) u_chan (
      .clk_sys(CLK),
      .rst_n  (Reset_n),
      .clkdiv (clkdiv),
      .right  (right[c]),
      .left   (left[c]),
      .steer  (steer[2*c +: 2]),
      .moving (moving[c]),
      .level  (level[2*c +: 2])
    );
  end

endmodule
